vga_draw_arbiter: RTL

Shares the single VGA adapter pixel-write port (x 8 b, y 7 b, colour 3 b, plot) between several sprite drawers: screen clear, rocket, alien grid and bullets. Each drawer requests the port, owns it for a whole sprite or clear burst, then releases it. Grants are round-robin, so no drawer starves. The block sits between the drawer datapaths and the VGA adapter, and is the only source of adapter `x`/`y`/`colour`/`plot`.

---
 rtl/vga_pkg.sv | 12 +
 rtl/rr_picker.sv | 32 +++
 rtl/vga_draw_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared screen geometry, pixel field widths and arbiter state encoding.
//   SCREEN_W/SCREEN_H  visible raster size
//   X_W/Y_W/COL_W      adapter pixel field widths
//   arb_state_t        ARB (choosing an owner) / OWN (owner drives the port)
package vga_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W = $clog2(SCREEN_W);
  localparam int Y_W = $clog2(SCREEN_H);
  localparam int COL_W = 3;
  typedef enum logic {ARB = 1'b0, OWN = 1'b1} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search, first req at or above ptr with wrap.
//   req     request vector
//   ptr     index searched first
//   found   any request present
//   idx     winning index
//   onehot  winning index as one-hot, zero when nothing found
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IW = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             found,
  output logic [IW-1:0]    idx,
  output logic [N_REQ-1:0] onehot
);
  logic [IW-1:0] j;
  // Walk from the farthest slot back to ptr so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx = '0;
    j = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N_REQ);
      if (req[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
    onehot = found ? N_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: round-robin owner of the single VGA adapter pixel-write port.
//   clk, reset          clock, synchronous active-low reset
//   req/done            per-drawer request level and release pulse (owner only)
//   x_in/y_in/colour_in packed per-drawer pixel, drawer i in slice i
//   plot_in             per-drawer write strobe
//   grant/busy          registered one-hot owner and any-owner flag
//   x_out..plot_out     registered adapter pixel port
//   timeout_flag        sticky hold-timeout indicator, only with DRAW_ARB_TIMEOUT_EN
module vga_draw_arbiter
  import vga_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         done,
  input  logic [X_W*N_REQ-1:0]     x_in,
  input  logic [Y_W*N_REQ-1:0]     y_in,
  input  logic [COL_W*N_REQ-1:0]   colour_in,
  input  logic [N_REQ-1:0]         plot_in,
  output logic [N_REQ-1:0]         grant,
  output logic [X_W-1:0]           x_out,
  output logic [Y_W-1:0]           y_out,
  output logic [COL_W-1:0]         colour_out,
  output logic                     plot_out,
  output logic                     busy
`ifdef DRAW_ARB_TIMEOUT_EN
  ,
  output logic                     timeout_flag
`endif
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  arb_state_t state;
  logic [IW-1:0] ptr, owner, idx;
  logic [N_REQ-1:0] onehot;
  logic found, hit_timeout, release_now;
  rr_picker #(.N_REQ(N_REQ), .IW(IW)) picker (
    .req(req),
    .ptr(ptr),
    .found(found),
    .idx(idx),
    .onehot(onehot)
  );
`ifdef DRAW_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] hold;
  assign hit_timeout = state == OWN && hold == CW'(TIMEOUT_CYCLES - 1);
  // Counter sits at zero through ARB, so it starts from zero on the first OWN cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold <= '0;
      timeout_flag <= 1'b0;
    end else begin
      hold <= state == OWN ? hold + 1'b1 : '0;
      if (hit_timeout) timeout_flag <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign hit_timeout = 1'b0;
`endif
  assign release_now = done[owner] | ~req[owner] | hit_timeout;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ARB;
      grant <= '0;
      busy <= 1'b0;
      ptr <= '0;
      owner <= '0;
      x_out <= '0;
      y_out <= '0;
      colour_out <= '0;
      plot_out <= 1'b0;
    end else if (state == ARB) begin
      plot_out <= 1'b0;
      if (found) begin
        state <= OWN;
        grant <= onehot;
        busy <= 1'b1;
        owner <= idx;
        ptr <= idx == IW'(N_REQ - 1) ? '0 : idx + 1'b1;
      end
    end else if (release_now) begin
      // The owner's pixel on the release edge is dropped; coordinates hold.
      state <= ARB;
      grant <= '0;
      busy <= 1'b0;
      plot_out <= 1'b0;
    end else begin
      x_out <= x_in[X_W*owner +: X_W];
      y_out <= y_in[Y_W*owner +: Y_W];
      colour_out <= colour_in[COL_W*owner +: COL_W];
      plot_out <= plot_in[owner];
    end
  end
endmodule
